debug_trace_fifo: RTL and testbench
===================================

// Module: debug_trace_fifo
// PURPOSE
//  Multi-lane commit-trace buffer between the core's debug port and the sim/difftest consumer.
//  Captures up to NLANE retired instructions per cycle (pc, device-access flag/addr, halt) into a DEPTH-entry FIFO.
//  Drains one entry per cycle over valid/ready, tags each entry with a sequence number,
//  reports drops on overflow, and sequences an orderly halt.
// PARAMETERS
//  NLANE  2   commit lanes per cycle, 1..4; lane 0 is oldest
//  DEPTH  16  FIFO entries, power of two, >= NLANE
//  XLEN   32  pc / device address width
//  SEQW   16  sequence-number width; wraps modulo 2^SEQW
// PORTS
//  clock           in   1           rising-edge clock
//  reset_n         in   1           asynchronous active-low reset
//  in_valid        in   NLANE       per-lane commit valid
//  in_pc           in   NLANE*XLEN  lane i pc at [i*XLEN +: XLEN]
//  in_dev_access   in   NLANE       lane accessed a device
//  in_dev_addr     in   NLANE*XLEN  device address per lane
//  in_halt         in   NLANE       lane is the halt instruction
//  clear           in   1           synchronous flush and restart
//  out_valid       out  1           head entry available
//  out_ready       in   1           consumer accepts head
//  out_pc          out  XLEN        head pc
//  out_dev_access  out  1           head device-access flag
//  out_dev_addr    out  XLEN        head device address
//  out_halt        out  1           head is the halt entry
//  out_seq         out  SEQW        head sequence number
//  level           out  clog2(DEPTH)+1  current occupancy
//  overflow        out  1           sticky: a commit cycle was dropped
//  drop_cnt        out  16          dropped entries, saturates at 16'hFFFF
//  halted          out  1           halt entry drained, FIFO empty
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty; out_valid, level, overflow, drop_cnt, halted = 0.
//    Next seq = 0. State = RUN. Data outputs 0.
//  - States:
//    - RUN: enqueue enabled.
//    - DRAIN: halt enqueued; enqueue disabled, dequeue continues.
//    - HALTED: entered when DRAIN and FIFO empty after the halt entry pops; halted=1; all in_* ignored.
//  - Candidate set per cycle = valid lanes in index order, truncated after the first valid lane with in_halt=1.
//    Valid lanes above it are discarded silently, not counted as drops. n = candidate count.
//  - free = DEPTH - level + (out_valid & out_ready); a same-cycle pop frees a slot.
//  - n <= free: all n written in lane order, compacted over invalid lanes.
//    Seq numbers are next_seq, next_seq+1, ...; next_seq += n; wrap modulo 2^SEQW.
//  - n > free: whole cycle dropped (all-or-none); overflow <= 1; drop_cnt += n, saturating; seq not advanced.
//  - Halt lane accepted -> RUN->DRAIN at same edge. Halt lane dropped -> remain RUN.
//  - Enqueue at edge k -> out_valid=1 after edge k (first entry visible next cycle); no bypass.
//  - out_* registered/array-read from head; held stable while out_valid & !out_ready.
//  - Pop on out_valid & out_ready.
//  - level = occupancy after edge; updated by pushes minus pop in the same cycle.
//  - clear (any state): FIFO emptied, next_seq=0, overflow=0, drop_cnt=0, halted=0, state=RUN.
//    Overrides same-cycle push and pop.
//  - Pointers wrap modulo DEPTH. Full: level==DEPTH. Empty: level==0.
//  - Async reset mid-drain discards all contents immediately.
// CONFIGURATION
//  - DEBUG_TRACE_TIMESTAMP_EN defined:
//    - 32-bit free-running cycle counter, reset 0, wraps, not affected by clear.
//    - Each entry stores the counter value of its enqueue cycle.
//    - Extra port out_cycle (out, 32).
//  - DEBUG_TRACE_TIMESTAMP_EN undefined: no counter, no out_cycle port, no storage.
// TESTING
//  1. Reset, then in_valid=2'b01, pc=0x8000_0000, ready=1
//     -> next cycle out_valid=1, out_pc=0x8000_0000, out_seq=0; level 1 then 0.
//  2. in_valid=2'b11, pcs 0x100/0x104, ready=0 for 8 cycles, DEPTH=16
//     -> level=16, no overflow. Ninth cycle -> overflow=1, drop_cnt=2, level stays 16.
//  3. Full FIFO, ready=1, in_valid=2'b01 -> accepted same cycle (free=1), level stays 16, overflow unchanged.
//  4. in_valid=2'b11, in_halt=2'b01 -> only lane 0 enqueued; later valid inputs ignored.
//     Halt entry pops -> halted=1 next cycle.
//  5. From HALTED or with 5 entries queued, assert clear
//     -> level=0, out_valid=0, halted=0, drop_cnt=0; next accepted entry out_seq=0.
//  6. Preload next_seq=0xFFFF via 65535 accepted entries, push 2
//     -> seqs 0xFFFF then 0x0000.
//     With DEBUG_TRACE_TIMESTAMP_EN: out_cycle equals the enqueue-cycle count.

Source files
------------

// File: rtl/debug_trace_fifo.sv
// Multi-lane commit-trace FIFO with sequence tagging, drop accounting and halt sequencing.
// Optional per-entry enqueue timestamp and out_cycle port when DEBUG_TRACE_TIMESTAMP_EN is defined.
module debug_trace_fifo #(
  parameter int NLANE = 2,
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int SEQW  = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NLANE-1:0]         in_valid,
  input  logic [NLANE*XLEN-1:0]    in_pc,
  input  logic [NLANE-1:0]         in_dev_access,
  input  logic [NLANE*XLEN-1:0]    in_dev_addr,
  input  logic [NLANE-1:0]         in_halt,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic                     out_dev_access,
  output logic [XLEN-1:0]          out_dev_addr,
  output logic                     out_halt,
  output logic [SEQW-1:0]          out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic                     halted,
`ifdef DEBUG_TRACE_TIMESTAMP_EN
  output logic [31:0]              out_cycle,
`endif
  output logic [1:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = LW + 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     count;
  logic [SEQW-1:0]   seq_q;
  logic              overflow_q;
  logic [15:0]       drop_q;

  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic              dev_mem  [DEPTH];
  logic [XLEN-1:0]   addr_mem [DEPTH];
  logic              halt_mem [DEPTH];
  logic [SEQW-1:0]   seq_mem  [DEPTH];

  logic [NLANE-1:0]  cand;
  logic [LW-1:0]     slot [NLANE];
  logic [LW-1:0]     n_cand;
  logic              cand_halt;
  logic [FW-1:0]     free_slots;
  logic              enq_en, pop, accept, drop;
  logic [16:0]       drop_sum;

  // Candidates are valid lanes in order, cut off after the first halt lane.
  always_comb begin
    cand      = '0;
    n_cand    = '0;
    cand_halt = 1'b0;
    for (int i = 0; i < NLANE; i++) begin
      slot[i] = n_cand;
      if (in_valid[i] && !cand_halt) begin
        cand[i] = 1'b1;
        n_cand  = n_cand + LW'(1);
        if (in_halt[i]) cand_halt = 1'b1;
      end
    end
  end

  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready && !clear;
  assign enq_en     = (state_q == S_RUN) && !clear;
  assign free_slots = FW'(DEPTH) - FW'(count) + FW'(pop);
  assign accept     = enq_en && (n_cand != '0) && (FW'(n_cand) <= free_slots);
  assign drop       = enq_en && (FW'(n_cand) > free_slots);
  assign drop_sum   = {1'b0, drop_q} + 17'(n_cand);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (accept && cand_halt) state_d = S_DRAIN;
      // The halt entry is always the last one queued, so the final pop is the halt.
      S_DRAIN: if (pop && count == LW'(1)) state_d = S_HALTED;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (clear) begin
      state_q    <= S_RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(n_cand);
        seq_q  <= seq_q + SEQW'(n_cand);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (accept ? n_cand : '0) - LW'(pop);
      if (drop) begin
        overflow_q <= 1'b1;
        drop_q     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < NLANE; i++) begin
        if (cand[i]) begin
          pc_mem  [wr_ptr + AW'(slot[i])] <= in_pc[i*XLEN +: XLEN];
          dev_mem [wr_ptr + AW'(slot[i])] <= in_dev_access[i];
          addr_mem[wr_ptr + AW'(slot[i])] <= in_dev_addr[i*XLEN +: XLEN];
          halt_mem[wr_ptr + AW'(slot[i])] <= in_halt[i];
          seq_mem [wr_ptr + AW'(slot[i])] <= seq_q + SEQW'(slot[i]);
        end
      end
    end
  end

  // Head data is gated so an empty FIFO presents zeros rather than stale storage.
  assign out_pc         = out_valid ? pc_mem[rd_ptr]   : '0;
  assign out_dev_access = out_valid ? dev_mem[rd_ptr]  : 1'b0;
  assign out_dev_addr   = out_valid ? addr_mem[rd_ptr] : '0;
  assign out_halt       = out_valid ? halt_mem[rd_ptr] : 1'b0;
  assign out_seq        = out_valid ? seq_mem[rd_ptr]  : '0;
  assign level          = count;
  assign overflow       = overflow_q;
  assign drop_cnt       = drop_q;
  assign halted         = (state_q == S_HALTED);
  assign state_dbg      = state_q;

`ifdef DEBUG_TRACE_TIMESTAMP_EN
  logic [31:0] cycle_q;
  logic [31:0] cycle_mem [DEPTH];

  // Free-running; deliberately untouched by clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cycle_q <= '0;
    else          cycle_q <= cycle_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < NLANE; i++) begin
        if (cand[i]) cycle_mem[wr_ptr + AW'(slot[i])] <= cycle_q;
      end
    end
  end

  assign out_cycle = out_valid ? cycle_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_debug_trace_fifo.sv
// Randomized self-checking bench for debug_trace_fifo against a queue-based reference model.
// Define DEBUG_TRACE_TIMESTAMP_EN for both files to also check out_cycle.
module tb_debug_trace_fifo;

  localparam int NLANE = 2;
  localparam int DEPTH = 16;
  localparam int XLEN  = 32;
  localparam int SEQW  = 16;
  localparam int EW    = 114;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                  reset_n;
  logic [NLANE-1:0]      in_valid, in_dev_access, in_halt;
  logic [NLANE*XLEN-1:0] in_pc, in_dev_addr;
  logic                  clear, out_ready;
  logic                  out_valid, out_dev_access, out_halt, overflow, halted;
  logic [XLEN-1:0]       out_pc, out_dev_addr;
  logic [SEQW-1:0]       out_seq;
  logic [4:0]            level;
  logic [15:0]           drop_cnt;
  logic [1:0]            state_dbg;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
  logic [31:0]           out_cycle;
`endif

  debug_trace_fifo #(.NLANE(NLANE), .DEPTH(DEPTH), .XLEN(XLEN), .SEQW(SEQW)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_dev_access(in_dev_access),
    .in_dev_addr(in_dev_addr), .in_halt(in_halt), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_dev_access(out_dev_access), .out_dev_addr(out_dev_addr),
    .out_halt(out_halt), .out_seq(out_seq), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt), .halted(halted),
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    .out_cycle(out_cycle),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  // Entry layout: pc[113:82] dev[81] addr[80:49] halt[48] seq[47:32] cyc[31:0]
  logic [EW-1:0] exp_q[$];
  int            m_seq, m_drop;
  bit            m_ovf, m_drain, m_halted;
  logic [31:0]   m_cyc;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [31:0] pc, input logic dev,
                                         input logic [31:0] addr, input logic halt,
                                         input logic [15:0] seq, input logic [31:0] cyc);
    return {pc, dev, addr, halt, seq, cyc};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_seq = 0; m_drop = 0; m_ovf = 0; m_drain = 0; m_halted = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_update();
    logic [EW-1:0] cands[$];
    bit hit_halt, pop, was_drain;
    int free;
    if (clear) begin
      model_reset();
    end else begin
      pop = (exp_q.size() != 0) && out_ready;
      was_drain = m_drain;
      hit_halt = 0;
      for (int i = 0; i < NLANE; i++) begin
        if (in_valid[i] && !hit_halt) begin
          cands.push_back(pack(in_pc[i*XLEN +: XLEN], in_dev_access[i], in_dev_addr[i*XLEN +: XLEN],
                               in_halt[i], 16'(m_seq + cands.size()), m_cyc));
          if (in_halt[i]) hit_halt = 1;
        end
      end
      free = DEPTH - exp_q.size() + int'(pop);
      if (pop) void'(exp_q.pop_front());
      if (!m_drain && !m_halted && cands.size() > 0) begin
        if (cands.size() <= free) begin
          foreach (cands[k]) exp_q.push_back(cands[k]);
          m_seq = (m_seq + cands.size()) % 65536;
          if (hit_halt) m_drain = 1;
        end else begin
          m_ovf = 1;
          m_drop = m_drop + cands.size();
          if (m_drop > 65535) m_drop = 65535;
        end
      end
      if (was_drain && pop && exp_q.size() == 0) begin
        m_drain = 0;
        m_halted = 1;
      end
    end
    m_cyc = m_cyc + 32'd1;
  endtask

  task automatic compare_all();
    logic [EW-1:0] h;
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("level", 64'(level), 64'(exp_q.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("halted", 64'(halted), 64'(m_halted));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check("out_pc", 64'(out_pc), 64'(h[113:82]));
      check("out_dev_access", 64'(out_dev_access), 64'(h[81]));
      check("out_dev_addr", 64'(out_dev_addr), 64'(h[80:49]));
      check("out_halt", 64'(out_halt), 64'(h[48]));
      check("out_seq", 64'(out_seq), 64'(h[47:32]));
`ifdef DEBUG_TRACE_TIMESTAMP_EN
      check("out_cycle", 64'(out_cycle), 64'(h[31:0]));
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives inputs, advances the model, then checks at the next falling edge.
  task automatic step(input logic [1:0] v, input logic [63:0] pcs, input logic [1:0] dv,
                      input logic [63:0] ad, input logic [1:0] h, input logic clr, input logic rdy);
    in_valid = v; in_pc = pcs; in_dev_access = dv; in_dev_addr = ad; in_halt = h;
    clear = clr; out_ready = rdy;
    model_update();
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic idle(input logic clr, input logic rdy);
    step(2'b00, 64'd0, 2'b00, 64'd0, 2'b00, clr, rdy);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = '0; in_pc = '0; in_dev_access = '0; in_dev_addr = '0; in_halt = '0;
    clear = 1'b0; out_ready = 1'b0;
    #1;
    model_reset();
    m_cyc = '0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_seq", 64'(out_seq), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  rv, rh, rd;
    logic [63:0] rp, ra;
    logic        rc, rr;
    int          thresh;

    reset_n = 1'b0;
    in_valid = '0; in_pc = '0; in_dev_access = '0; in_dev_addr = '0; in_halt = '0;
    clear = 1'b0; out_ready = 1'b0;
    m_cyc = '0;
    @(negedge clock);
    do_reset();

    // Single commit becomes visible the next cycle, then drains.
    step(2'b01, {32'd0, 32'h8000_0000}, 2'b00, 64'd0, 2'b00, 1'b0, 1'b1);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_pc", 64'(out_pc), 64'h8000_0000);
    check("t1_seq", 64'(out_seq), 64'd0);
    check("t1_level1", 64'(level), 64'd1);
    idle(1'b0, 1'b1);
    check("t1_level0", 64'(level), 64'd0);

    // Fill with two lanes per cycle, then overflow on the ninth cycle.
    idle(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(2'b11, {32'h104, 32'h100}, 2'b10, {32'hA0, 32'd0}, 2'b00, 1'b0, 1'b0);
    check("t2_level_full", 64'(level), 64'd16);
    check("t2_no_ovf", 64'(overflow), 64'd0);
    step(2'b11, {32'h104, 32'h100}, 2'b00, 64'd0, 2'b00, 1'b0, 1'b0);
    check("t2_ovf", 64'(overflow), 64'd1);
    check("t2_drop", 64'(drop_cnt), 64'd2);
    check("t2_level_hold", 64'(level), 64'd16);

    // Full FIFO with a same-cycle pop frees one slot.
    step(2'b01, {32'd0, 32'h200}, 2'b00, 64'd0, 2'b00, 1'b0, 1'b1);
    check("t3_level", 64'(level), 64'd16);
    check("t3_drop", 64'(drop_cnt), 64'd2);

    // Halt on lane 0 truncates lane 1 and stops further enqueue.
    idle(1'b1, 1'b0);
    step(2'b11, {32'h304, 32'h300}, 2'b00, 64'd0, 2'b01, 1'b0, 1'b0);
    check("t4_level", 64'(level), 64'd1);
    check("t4_halt_head", 64'(out_halt), 64'd1);
    step(2'b11, {32'h30C, 32'h308}, 2'b00, 64'd0, 2'b00, 1'b0, 1'b0);
    check("t4_ignored", 64'(level), 64'd1);
    idle(1'b0, 1'b1);
    check("t4_halted", 64'(halted), 64'd1);
    step(2'b11, {32'h314, 32'h310}, 2'b00, 64'd0, 2'b00, 1'b0, 1'b1);
    check("t4_halted_ignore", 64'(level), 64'd0);

    // Clear from HALTED, then from a partially filled FIFO.
    idle(1'b1, 1'b0);
    check("t5_halted_clr", 64'(halted), 64'd0);
    for (int i = 0; i < 5; i++) step(2'b01, {32'd0, 32'(32'h400 + i*4)}, 2'b00, 64'd0, 2'b00, 1'b0, 1'b0);
    check("t5_level5", 64'(level), 64'd5);
    idle(1'b1, 1'b1);
    check("t5_level0", 64'(level), 64'd0);
    check("t5_valid0", 64'(out_valid), 64'd0);
    step(2'b10, {32'h500, 32'd0}, 2'b00, 64'd0, 2'b00, 1'b0, 1'b0);
    check("t5_seq0", 64'(out_seq), 64'd0);

    // Sequence-number wrap.
    idle(1'b1, 1'b0);
    for (int i = 0; i < 65535; i++) step(2'b01, {32'd0, $urandom}, 2'b00, 64'd0, 2'b00, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    step(2'b11, {32'h604, 32'h600}, 2'b00, 64'd0, 2'b00, 1'b0, 1'b0);
    check("t6_seq_ffff", 64'(out_seq), 64'hFFFF);
    idle(1'b0, 1'b1);
    check("t6_seq_0000", 64'(out_seq), 64'h0000);

    // Random traffic with a mid-run asynchronous reset.
    idle(1'b1, 1'b1);
    thresh = 6;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) thresh = $urandom_range(1, 9);
      if (i == 1500) begin
        in_valid = 2'b11; out_ready = 1'b0;
        @(posedge clock);
        #2;
        do_reset();
      end
      rv = 2'($urandom_range(0, 3));
      rh = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      rd = 2'($urandom_range(0, 3));
      rp = {$urandom, $urandom};
      ra = {$urandom, $urandom};
      rc = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      rr = ($urandom_range(0, 9) < thresh);
      step(rv, rp, rd, ra, rh, rc, rr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
